// File: rtl/sae_min_search.sv
// sae_min_search: raster-order minimum-SAE tracker for the motion-search window.
// Consumes SEARCH_W*SEARCH_H SAE values per search and reports the first
// minimum in raster order, with a one-cycle done pulse.
// Optional feature macro: SAE_ZERO_EXIT_EN (a zero SAE ends the search early).
module sae_min_search #(
    parameter int unsigned SEARCH_W  = 3,
    parameter int unsigned SEARCH_H  = 3,
    parameter int unsigned SAE_WIDTH = 10,
    parameter int unsigned IDX_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic [SAE_WIDTH-1:0] i_sae,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [SAE_WIDTH-1:0] o_best_sae,
    output logic [IDX_WIDTH-1:0] o_best_x,
    output logic [IDX_WIDTH-1:0] o_best_y
);

    localparam logic [IDX_WIDTH-1:0] X_LAST  = IDX_WIDTH'(SEARCH_W - 1);
    localparam logic [IDX_WIDTH-1:0] Y_LAST  = IDX_WIDTH'(SEARCH_H - 1);
    localparam logic [SAE_WIDTH-1:0] SAE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_WIDTH-1:0] x_cnt;
    logic [IDX_WIDTH-1:0] y_cnt;
    logic [IDX_WIDTH-1:0] x_nxt;
    logic [IDX_WIDTH-1:0] y_nxt;
    logic [IDX_WIDTH-1:0] best_x_nxt;
    logic [IDX_WIDTH-1:0] best_y_nxt;
    logic [SAE_WIDTH-1:0] best_sae_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;
    logic                 first_pos;
    logic                 last_pos;
    logic                 zero_hit;

    // First candidate forces a load so a genuine all-ones SAE is still recorded
    assign first_pos = (x_cnt == '0) && (y_cnt == '0);
    assign last_pos  = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

`ifdef SAE_ZERO_EXIT_EN
    // A perfect match cannot be beaten, so end the search on it
    assign zero_hit = (i_sae == '0);
`else
    assign zero_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter and best-candidate update logic
    always_comb begin
        state_nxt    = state;
        x_nxt        = x_cnt;
        y_nxt        = y_cnt;
        best_sae_nxt = o_best_sae;
        best_x_nxt   = o_best_x;
        best_y_nxt   = o_best_y;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt    = SCAN;
                    x_nxt        = '0;
                    y_nxt        = '0;
                    best_sae_nxt = SAE_MAX;
                    best_x_nxt   = '0;
                    best_y_nxt   = '0;
                end
            end
            SCAN: begin
                if (i_valid) begin
                    if (first_pos || (i_sae < o_best_sae)) begin
                        best_sae_nxt = i_sae;
                        best_x_nxt   = x_cnt;
                        best_y_nxt   = y_cnt;
                    end
                    if (last_pos || zero_hit) begin
                        state_nxt = DONE;
                    end else if (x_cnt == X_LAST) begin
                        x_nxt = '0;
                        y_nxt = y_cnt + IDX_WIDTH'(1);
                    end else begin
                        x_nxt = x_cnt + IDX_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == SCAN);
        done_nxt = (state_nxt == DONE);
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_best_sae <= SAE_MAX;
            o_best_x   <= '0;
            o_best_y   <= '0;
        end else begin
            x_cnt      <= x_nxt;
            y_cnt      <= y_nxt;
            o_busy     <= busy_nxt;
            o_done     <= done_nxt;
            o_best_sae <= best_sae_nxt;
            o_best_x   <= best_x_nxt;
            o_best_y   <= best_y_nxt;
        end
    end

endmodule

// File: tb/tb_sae_min_search.sv
// tb_sae_min_search: directed self-checking bench for sae_min_search (3x3 window).
module tb_sae_min_search;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic       i_valid;
    logic [9:0] i_sae;
    logic       o_busy;
    logic       o_done;
    logic [9:0] o_best_sae;
    logic [3:0] o_best_x;
    logic [3:0] o_best_y;

    int n_checks;
    int n_fail;

    sae_min_search #(
        .SEARCH_W (3),
        .SEARCH_H (3),
        .SAE_WIDTH(10),
        .IDX_WIDTH(4)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_valid   (i_valid),
        .i_sae     (i_sae),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_best_sae(o_best_sae),
        .o_best_x  (o_best_x),
        .o_best_y  (o_best_y)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Run one search from idle: pulse start, feed n candidates with optional
    // random stalls. Reports edges from the start edge to the done cycle,
    // whether done appeared before the final accept, and best_sae right after start.
    task automatic feed(input int vals[9], input int n, input int max_gap,
                        input bit hold_start, input bit start_with_valid,
                        output int edges, output bit early_done,
                        output logic [9:0] sae_at_start);
        int gap;
        edges      = 0;
        early_done = 1'b0;
        i_start    = 1'b1;
        i_valid    = start_with_valid;
        i_sae      = 10'd0;
        tick();
        sae_at_start = o_best_sae;
        i_start = hold_start;
        i_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                i_valid = 1'b0;
                i_sae   = 10'd0;
                tick();
                edges++;
                if (o_done) early_done = 1'b1;
            end
            i_valid = 1'b1;
            i_sae   = 10'(vals[k]);
            tick();
            edges++;
            i_valid = 1'b0;
            if (k < n - 1 && o_done) early_done = 1'b1;
        end
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_sae = 10'd0;
        tick(); tick();
        i_rst = 1'b0;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", o_busy); end
        n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", o_done); end
        n_checks++; if (o_best_sae !== 10'd1023) begin n_fail++; $display("FAIL reset_sae: got %0d want 1023", o_best_sae); end
        n_checks++; if (o_best_x !== 4'd0 || o_best_y !== 4'd0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d want 0,0", o_best_x, o_best_y); end
    endtask

    task automatic test_basic();
        int vals[9] = '{50, 40, 60, 40, 30, 70, 30, 90, 80};
        int edges; bit early; logic [9:0] s0;
        feed(vals, 9, 0, 1'b0, 1'b0, edges, early, s0);
        n_checks++; if (s0 !== 10'd1023) begin n_fail++; $display("FAIL basic_init: got %0d want 1023", s0); end
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL basic_early_done: got %0b want 0", early); end
        n_checks++; if (edges != 9) begin n_fail++; $display("FAIL basic_latency: got %0d want 9", edges); end
        n_checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: done=%0b busy=%0b want 1,0", o_done, o_busy); end
        n_checks++; if (o_best_sae !== 10'd30 || o_best_x !== 4'd1 || o_best_y !== 4'd1) begin n_fail++; $display("FAIL basic_result: got %0d/%0d/%0d want 30/1/1", o_best_sae, o_best_x, o_best_y); end
        tick();
        n_checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: done=%0b busy=%0b want 0,0", o_done, o_busy); end
        n_checks++; if (o_best_sae !== 10'd30) begin n_fail++; $display("FAIL basic_hold: got %0d want 30", o_best_sae); end
    endtask

    task automatic test_stall();
        int vals[9] = '{50, 40, 60, 40, 30, 70, 30, 90, 80};
        int edges; bit early; logic [9:0] s0;
        feed(vals, 9, 3, 1'b0, 1'b0, edges, early, s0);
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL stall_early_done: got %0b want 0", early); end
        n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %0b want 1", o_done); end
        n_checks++; if (o_best_sae !== 10'd30 || o_best_x !== 4'd1 || o_best_y !== 4'd1) begin n_fail++; $display("FAIL stall_result: got %0d/%0d/%0d want 30/1/1", o_best_sae, o_best_x, o_best_y); end
        tick();
    endtask

    task automatic test_all_ones();
        int vals[9] = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
        int edges; bit early; logic [9:0] s0;
        feed(vals, 9, 0, 1'b0, 1'b0, edges, early, s0);
        n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL ones_done: got %0b want 1", o_done); end
        n_checks++; if (o_best_sae !== 10'd1023 || o_best_x !== 4'd0 || o_best_y !== 4'd0) begin n_fail++; $display("FAIL ones_result: got %0d/%0d/%0d want 1023/0/0", o_best_sae, o_best_x, o_best_y); end
        tick();
    endtask

    task automatic test_ignore();
        int vals[9] = '{50, 40, 60, 40, 30, 70, 30, 90, 80};
        int edges; bit early; logic [9:0] s0;
        // valid pulses while idle must not disturb the held result
        i_valid = 1'b1; i_sae = 10'd5;
        tick(); tick(); tick();
        i_valid = 1'b0;
        n_checks++; if (o_busy !== 1'b0 || o_best_sae !== 10'd1023 || o_best_x !== 4'd0) begin n_fail++; $display("FAIL ignore_idle_valid: busy=%0b sae=%0d x=%0d want 0,1023,0", o_busy, o_best_sae, o_best_x); end
        // start held through the scan, plus valid together with start
        feed(vals, 9, 0, 1'b1, 1'b1, edges, early, s0);
        n_checks++; if (edges != 9 || early !== 1'b0 || o_done !== 1'b1) begin n_fail++; $display("FAIL ignore_latency: edges=%0d early=%0b done=%0b want 9,0,1", edges, early, o_done); end
        n_checks++; if (o_best_sae !== 10'd30 || o_best_x !== 4'd1 || o_best_y !== 4'd1) begin n_fail++; $display("FAIL ignore_result: got %0d/%0d/%0d want 30/1/1", o_best_sae, o_best_x, o_best_y); end
        // start during DONE is ignored
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_fail++; $display("FAIL ignore_done_start: busy=%0b done=%0b want 0,0", o_busy, o_done); end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        saw_done = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_sae = 10'(5 - k);
            tick();
        end
        i_rst = 1'b1; i_valid = 1'b1; i_sae = 10'd1;
        tick();
        i_rst = 1'b0; i_valid = 1'b0;
        n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: busy=%0b done=%0b want 0,0", o_busy, o_done); end
        n_checks++; if (o_best_sae !== 10'd1023 || o_best_x !== 4'd0 || o_best_y !== 4'd0) begin n_fail++; $display("FAIL rstmid_result: got %0d/%0d/%0d want 1023/0/0", o_best_sae, o_best_x, o_best_y); end
        for (int k = 0; k < 8; k++) begin
            i_valid = 1'b1; i_sae = 10'd7;
            tick();
            if (o_done || o_busy) saw_done = 1'b1;
        end
        i_valid = 1'b0;
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got %0b want 0", saw_done); end
    endtask

    task automatic test_zero();
        int vals[9] = '{50, 40, 0, 60, 0, 70, 30, 90, 80};
        int edges; bit early; logic [9:0] s0;
        int n_exp;
`ifdef SAE_ZERO_EXIT_EN
        n_exp = 3;
`else
        n_exp = 9;
`endif
        feed(vals, n_exp, 0, 1'b0, 1'b0, edges, early, s0);
        n_checks++; if (edges != n_exp || early !== 1'b0 || o_done !== 1'b1) begin n_fail++; $display("FAIL zero_latency: edges=%0d early=%0b done=%0b want %0d,0,1", edges, early, o_done, n_exp); end
        n_checks++; if (o_best_sae !== 10'd0 || o_best_x !== 4'd2 || o_best_y !== 4'd0) begin n_fail++; $display("FAIL zero_result: got %0d/%0d/%0d want 0/2/0", o_best_sae, o_best_x, o_best_y); end
        tick();
    endtask

    task automatic test_back_to_back();
        int vals_a[9] = '{50, 40, 60, 40, 30, 70, 30, 90, 80};
        int vals_b[9] = '{900, 800, 700, 600, 500, 400, 300, 200, 100};
        int edges; bit early; logic [9:0] s0;
        feed(vals_a, 9, 0, 1'b0, 1'b0, edges, early, s0);
        n_checks++; if (o_best_sae !== 10'd30 || o_done !== 1'b1) begin n_fail++; $display("FAIL b2b_first: sae=%0d done=%0b want 30,1", o_best_sae, o_done); end
        tick();
        feed(vals_b, 9, 0, 1'b0, 1'b0, edges, early, s0);
        n_checks++; if (s0 !== 10'd1023) begin n_fail++; $display("FAIL b2b_reinit: got %0d want 1023", s0); end
        n_checks++; if (edges != 9 || o_done !== 1'b1) begin n_fail++; $display("FAIL b2b_latency: edges=%0d done=%0b want 9,1", edges, o_done); end
        n_checks++; if (o_best_sae !== 10'd100 || o_best_x !== 4'd2 || o_best_y !== 4'd2) begin n_fail++; $display("FAIL b2b_result: got %0d/%0d/%0d want 100/2/2", o_best_sae, o_best_x, o_best_y); end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_valid  = 1'b0;
        i_sae    = 10'd0;
        test_reset();
        test_basic();
        test_stall();
        test_all_ones();
        test_reset_mid();
        test_ignore();
        test_zero();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
